cl_serial_unit: RTL and testbench

- Parametrised, multi-cycle successor of the single-bit logic cell.
- Applies one of four bitwise logic operations (selected by a 2-bit code) to two WIDTH-bit operands.
- Processes SLICE bits per clock, LSB slice first, with valid/ready handshakes on input and output.
- Sits as the logic-operation unit beside the adder in the practice datapath.

---
 rtl/cl_serial_unit_if.sv | 26 ++
 rtl/cl_serial_unit.sv | 154 +++++++++++++++
 tb/tb_cl_serial_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cl_serial_unit_if.sv
// cl_serial_unit_if: operand/result handshake bundle for the serial logic unit.
// The master side (producer/consumer) drives operands, op code and out_ready;
// the slave side (the unit) drives the ready/valid status, result and busy.
interface cl_serial_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       s;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, a, b, s, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a, b, s, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/cl_serial_unit.sv
// cl_serial_unit: multi-cycle bitwise logic unit (AND / OR / XOR / NOT a).
// Operands are captured on accept, then SLICE result bits are produced per
// clock, LSB slice first, and the full result is held until the consumer
// takes it.
// Optional feature macro: CL_ZERO_FLAG_EN adds a 'zero' output that is high
// while out_valid is high and the completed result is all zeros.
module cl_serial_unit #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  cl_serial_unit_if.slave bus
`ifdef CL_ZERO_FLAG_EN
  ,
  output logic            zero
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OUT  = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       s_r;
  logic [WIDTH-1:0] result_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             accept_s;
  logic [WIDTH-1:0] op_word_s;
  logic [31:0]      base_s;
  logic [SLICE-1:0] slice_s;

  // Full-width logic operation; only one slice of it is committed per cycle.
  function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [1:0]       code);
    logic [WIDTH-1:0] r;
    case (code)
      2'b00:   r = x & y;
      2'b01:   r = x | y;
      2'b10:   r = x ^ y;
      2'b11:   r = ~x;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Select the slice addressed by the counter from the captured operands.
  always_comb begin
    op_word_s = logic_op(a_r, b_r, s_r);
    base_s    = 32'(cnt_r) * 32'(SLICE);
    slice_s   = op_word_s[base_s +: SLICE];
  end

  // Next-state decode; operands only matter at the IDLE accept.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_s = OUT;
        end else begin
          state_s = RUN;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, status flags, operand capture and slice-by-slice result fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      cnt_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      s_r         <= 2'b00;
      result_r    <= '0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == OUT);
      busy_r      <= (state_s == RUN) || (state_s == OUT);
      if (accept_s) begin
        a_r      <= bus.a;
        b_r      <= bus.b;
        s_r      <= bus.s;
        result_r <= '0;
        cnt_r    <= '0;
      end else if (state_r == RUN) begin
        result_r[base_s +: SLICE] <= slice_s;
        if (cnt_r != LAST_CNT) begin
          cnt_r <= cnt_r + CW'(1);
        end
      end
    end
  end

`ifdef CL_ZERO_FLAG_EN
  logic zero_acc_r;

  // Accumulate "every slice so far was zero" across the RUN phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_acc_r <= 1'b0;
    end else if (accept_s) begin
      zero_acc_r <= 1'b1;
    end else if (state_r == RUN) begin
      zero_acc_r <= zero_acc_r & (slice_s == '0);
    end
  end

  assign zero = zero_acc_r & out_valid_r;
`endif

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.result    = result_r;

endmodule

// File: tb/tb_cl_serial_unit.sv
// tb_cl_serial_unit: directed bench for cl_serial_unit with three parameter
// sets (8/2 main, 8/8 and 16/1 sweep). Zero-flag checks compile in when
// CL_ZERO_FLAG_EN is defined.
module tb_cl_serial_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cl_serial_unit_if #(.WIDTH(8))  b8 ();
  cl_serial_unit_if #(.WIDTH(8))  b88 ();
  cl_serial_unit_if #(.WIDTH(16)) b16 ();

`ifdef CL_ZERO_FLAG_EN
  logic zero8, zero88, zero16;
`endif

  cl_serial_unit #(.WIDTH(8), .SLICE(2)) u_main (
    .clk(clk), .rst_n(rst_n), .bus(b8)
`ifdef CL_ZERO_FLAG_EN
    , .zero(zero8)
`endif
  );

  cl_serial_unit #(.WIDTH(8), .SLICE(8)) u_w8s8 (
    .clk(clk), .rst_n(rst_n), .bus(b88)
`ifdef CL_ZERO_FLAG_EN
    , .zero(zero88)
`endif
  );

  cl_serial_unit #(.WIDTH(16), .SLICE(1)) u_w16s1 (
    .clk(clk), .rst_n(rst_n), .bus(b16)
`ifdef CL_ZERO_FLAG_EN
    , .zero(zero16)
`endif
  );

  task automatic test_reset();
    checks++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.busy !== 1'b0 || b8.result !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b res=%h, want 1 0 0 00",
               b8.in_ready, b8.out_valid, b8.busy, b8.result);
    end
    checks++;
    if (b88.result !== 8'h00 || b16.result !== 16'h0000 || b16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_sweep: res88=%h res16=%h rdy16=%b, want 00 0000 1",
               b88.result, b16.result, b16.in_ready);
    end
  endtask

  // One full operation on the 8/2 unit; entered at posedge+1 in IDLE.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                        input logic [7:0] exp, input string name);
    int n;
    b8.a = a; b8.b = b; b8.s = s; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    checks++;
    if (b8.in_ready !== 1'b0 || b8.busy !== 1'b1 || b8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_run: rdy=%b busy=%b vld=%b, want 0 1 0", name, b8.in_ready, b8.busy, b8.out_valid);
    end
    n = 0;
    while (b8.out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, want 4", name, n);
    end
    checks++;
    if (b8.result !== exp) begin
      errors++;
      $display("FAIL %s_result: got %h, want %h", name, b8.result, exp);
    end
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    checks++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.busy !== 1'b0 || b8.result !== exp) begin
      errors++;
      $display("FAIL %s_release: rdy=%b vld=%b busy=%b res=%h, want 1 0 0 %h",
               name, b8.in_ready, b8.out_valid, b8.busy, b8.result, exp);
    end
  endtask

  task automatic test_logic_ops();
    do_op8(8'hA5, 8'h3C, 2'b00, 8'h24, "and");
    do_op8(8'hA5, 8'h3C, 2'b01, 8'hBD, "or");
    do_op8(8'hA5, 8'h3C, 2'b10, 8'h99, "xor");
    do_op8(8'hA5, 8'h3C, 2'b11, 8'h5A, "not");
    do_op8(8'hA5, 8'hFF, 2'b11, 8'h5A, "not_b_ignored");
  endtask

  task automatic test_back_pressure();
    int n;
    b8.a = 8'hA5; b8.b = 8'h3C; b8.s = 2'b00; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    n = 0;
    while (b8.out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    b8.a = 8'hFF; b8.b = 8'hFF; b8.s = 2'b01; b8.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (b8.out_valid !== 1'b1 || b8.result !== 8'h24 || b8.busy !== 1'b1 || b8.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld=%b res=%h busy=%b rdy=%b, want 1 24 1 0",
                 i, b8.out_valid, b8.result, b8.busy, b8.in_ready);
      end
      @(posedge clk); #1;
    end
    b8.in_valid = 1'b0;
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    checks++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.result !== 8'h24) begin
      errors++;
      $display("FAIL bp_release: rdy=%b vld=%b res=%h, want 1 0 24", b8.in_ready, b8.out_valid, b8.result);
    end
    @(posedge clk); #1;
    checks++;
    if (b8.in_ready !== 1'b1 || b8.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle_stays: rdy=%b busy=%b, want 1 0", b8.in_ready, b8.busy);
    end
  endtask

  task automatic test_reset_mid_op();
    b8.a = 8'hA5; b8.b = 8'h3C; b8.s = 2'b01; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (b8.result !== 8'h0D) begin
      errors++;
      $display("FAIL midop_partial: got %h, want 0d", b8.result);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b8.result !== 8'h00 || b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1 || b8.busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: res=%h vld=%b rdy=%b busy=%b, want 00 0 1 0",
               b8.result, b8.out_valid, b8.in_ready, b8.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op8(8'h3C, 8'hA5, 2'b10, 8'h99, "after_reset");
  endtask

  task automatic test_sweep_w8s8();
    int n;
    b88.a = 8'hF0; b88.b = 8'h0F; b88.s = 2'b10; b88.in_valid = 1'b1;
    @(posedge clk); #1;
    b88.in_valid = 1'b0;
    n = 0;
    while (b88.out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != 1 || b88.result !== 8'hFF) begin
      errors++;
      $display("FAIL w8s8: latency %0d res %h, want 1 ff", n, b88.result);
    end
    b88.out_ready = 1'b1;
    @(posedge clk); #1;
    b88.out_ready = 1'b0;
  endtask

  task automatic test_sweep_w16s1();
    int n;
    b16.a = 16'h1234; b16.b = 16'h00FF; b16.s = 2'b00; b16.in_valid = 1'b1;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    n = 0;
    while (b16.out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != 16 || b16.result !== 16'h0034) begin
      errors++;
      $display("FAIL w16s1: latency %0d res %h, want 16 0034", n, b16.result);
    end
    b16.out_ready = 1'b1;
    @(posedge clk); #1;
    b16.out_ready = 1'b0;
  endtask

`ifdef CL_ZERO_FLAG_EN
  task automatic test_zero_flag();
    int n;
    b8.a = 8'h0F; b8.b = 8'hF0; b8.s = 2'b00; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    checks++;
    if (zero8 !== 1'b0) begin
      errors++;
      $display("FAIL zero_during_run: got %b, want 0", zero8);
    end
    n = 0;
    while (b8.out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (b8.result !== 8'h00 || zero8 !== 1'b1) begin
      errors++;
      $display("FAIL zero_set: res=%h zero=%b, want 00 1", b8.result, zero8);
    end
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    checks++;
    if (zero8 !== 1'b0) begin
      errors++;
      $display("FAIL zero_after_release: got %b, want 0", zero8);
    end
    b8.s = 2'b01; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    n = 0;
    while (b8.out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (b8.result !== 8'hFF || zero8 !== 1'b0) begin
      errors++;
      $display("FAIL zero_clear: res=%h zero=%b, want ff 0", b8.result, zero8);
    end
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
  endtask
`endif

  initial begin
    b8.in_valid = 1'b0;  b8.a = 8'h00;  b8.b = 8'h00;  b8.s = 2'b00;  b8.out_ready = 1'b0;
    b88.in_valid = 1'b0; b88.a = 8'h00; b88.b = 8'h00; b88.s = 2'b00; b88.out_ready = 1'b0;
    b16.in_valid = 1'b0; b16.a = 16'h0000; b16.b = 16'h0000; b16.s = 2'b00; b16.out_ready = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_logic_ops();
    test_back_pressure();
    test_reset_mid_op();
    test_sweep_w8s8();
    test_sweep_w16s1();
`ifdef CL_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
